// File: rtl/shape_pkg.sv
// Shared types and width helpers for the shape column generator.
//   mode_e  : per-request rendering mode (matches the 2-bit mode port encoding)
//   state_e : column generator FSM states
//   coord_w : signed width holding any column/row difference
//   d2_w    : width holding dx*dx + dy*dy without truncation
package shape_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_FILLED = 2'd1,
    MODE_SHELL  = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  // One extra bit over the largest coordinate so a difference is signed-safe.
  function automatic int coord_w(input int num_cols, input int num_rows);
    return $clog2((num_cols > num_rows) ? num_cols : num_rows) + 1;
  endfunction

  // Each square of a COORD_W-bit magnitude fits in 2*COORD_W-2 bits, so the
  // sum of two fits comfortably in 2*COORD_W.
  function automatic int d2_w(input int cw);
    return 2 * cw;
  endfunction

  localparam int DEF_COORD_W = coord_w(64, 64);
  localparam int DEF_D2_W    = d2_w(DEF_COORD_W);

endpackage

// File: rtl/shape_pixel_eval.sv
// Combinational per-pixel test for one display pixel.
//   dx, dy : signed offset of the pixel from the circle centre
//   r2     : outer radius squared
//   ri2    : inner (shell) radius squared, zero when the shell covers the disc
//   mode   : rendering mode
//   lit    : pixel takes the request colour
module shape_pixel_eval
  import shape_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int D2_W    = DEF_D2_W
) (
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic        [D2_W-1:0]    r2,
  input  logic        [D2_W-1:0]    ri2,
  input  mode_e                     mode,
  output logic                      lit
);

  logic [COORD_W-1:0] dx_abs;
  logic [COORD_W-1:0] dy_abs;
  logic [D2_W-1:0]    d2;

  // Squaring magnitudes keeps the multiply unsigned and the sum exact.
  assign dx_abs = dx[COORD_W-1] ? $unsigned(-dx) : $unsigned(dx);
  assign dy_abs = dy[COORD_W-1] ? $unsigned(-dy) : $unsigned(dy);
  assign d2     = D2_W'(dx_abs) * D2_W'(dx_abs) + D2_W'(dy_abs) * D2_W'(dy_abs);

  // NOTE: lit gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    lit = 1'b0;
    unique case (mode)
      MODE_OFF:    lit = 1'b0;
      MODE_FILLED: lit = (d2 <= r2);
      MODE_SHELL:  lit = (d2 >= ri2) && (d2 <= r2);
      MODE_SOLID:  lit = 1'b1;
    endcase
  end

endmodule

// File: rtl/shape_column_gen.sv
// Renders two display columns of a circular cross-section into a per-pixel
// colour buffer, ROWS_PER_CYCLE rows per clock, and hands the finished frame
// over with a valid/ready handshake.
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   req_valid / req_ready     : request handshake (accepted only in IDLE)
//   column_index1/2           : x of the two rendered columns
//   center_x, center_y        : circle centre
//   radius, shell_w           : outer radius, shell thickness (SHELL mode)
//   mode, color               : rendering mode and lit-pixel colour
//   out_valid / out_ready     : frame handshake
//   columns[c][y]             : c=0 -> column_index1, c=1 -> column_index2
module shape_column_gen
  import shape_pkg::*;
#(
  parameter int NUM_COLS       = 64,
  parameter int NUM_ROWS       = 64,
  parameter int RGB_RES        = 9,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [$clog2(NUM_COLS)-1:0]               column_index1,
  input  logic [$clog2(NUM_COLS)-1:0]               column_index2,
  input  logic [$clog2(NUM_COLS)-1:0]               center_x,
  input  logic [$clog2(NUM_ROWS)-1:0]               center_y,
  input  logic [$clog2(NUM_ROWS)-1:0]               radius,
  input  logic [$clog2(NUM_ROWS)-1:0]               shell_w,
  input  logic [1:0]                                mode,
  input  logic [RGB_RES-1:0]                        color,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]     columns
);

  localparam int CX_W    = $clog2(NUM_COLS);
  localparam int CY_W    = $clog2(NUM_ROWS);
  localparam int COORD_W = coord_w(NUM_COLS, NUM_ROWS);
  localparam int D2_W    = d2_w(COORD_W);
  localparam logic [CY_W-1:0] LAST_ROW = CY_W'(NUM_ROWS - ROWS_PER_CYCLE);

  if (NUM_ROWS % ROWS_PER_CYCLE != 0) begin : g_bad_rows_per_cycle
    $error("shape_column_gen: ROWS_PER_CYCLE must divide NUM_ROWS");
  end

  state_e state_q, state_d;

  // Request fields captured at accept so later input changes cannot disturb
  // the frame in progress.
  logic [CX_W-1:0]    col1_q, col2_q, cx_q;
  logic [CY_W-1:0]    cy_q, rad_q, shw_q;
  mode_e              mode_q;
  logic [RGB_RES-1:0] color_q;
  logic [CY_W-1:0]    row_q;

  logic accept;
  logic scanning;

  logic [CY_W-1:0] ri;
  logic [D2_W-1:0] r2, ri2;

  logic signed [COORD_W-1:0]               dx [2];
  logic [ROWS_PER_CYCLE-1:0][CY_W-1:0]     row_idx;
  logic [1:0][ROWS_PER_CYCLE-1:0][RGB_RES-1:0] pix;

  // ---------------------------------------------------------------- FSM
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (row_q == LAST_ROW) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign scanning = (state_q == ST_SCAN);

  // ------------------------------------------------------- geometry terms
  // Inner radius clamps at zero, making SHELL degenerate to FILLED.
  assign ri  = (rad_q > shw_q) ? (rad_q - shw_q) : '0;
  assign r2  = D2_W'(rad_q) * D2_W'(rad_q);
  assign ri2 = D2_W'(ri) * D2_W'(ri);

  // Zero-extend before subtracting; the extra bit makes the result a correct
  // two's-complement offset.
  assign dx[0] = COORD_W'(col1_q) - COORD_W'(cx_q);
  assign dx[1] = COORD_W'(col2_q) - COORD_W'(cx_q);

  for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_row
    logic signed [COORD_W-1:0] dy;

    assign row_idx[k] = row_q + CY_W'(k);
    assign dy         = COORD_W'(row_idx[k]) - COORD_W'(cy_q);

    for (genvar c = 0; c < 2; c++) begin : g_col
      logic lit;

      shape_pixel_eval #(
        .COORD_W (COORD_W),
        .D2_W    (D2_W)
      ) u_eval (
        .dx   (dx[c]),
        .dy   (dy),
        .r2   (r2),
        .ri2  (ri2),
        .mode (mode_q),
        .lit  (lit)
      );

      assign pix[c][k] = lit ? color_q : '0;
    end
  end

  // ------------------------------------------------------------ datapath
  // NOTE: the column buffer is reset along with the control state because
  // its all-zero contents are observable straight after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      col1_q  <= '0;
      col2_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      rad_q   <= '0;
      shw_q   <= '0;
      mode_q  <= MODE_OFF;
      color_q <= '0;
      row_q   <= '0;
      columns <= '0;
    end else if (accept) begin
      col1_q  <= column_index1;
      col2_q  <= column_index2;
      cx_q    <= center_x;
      cy_q    <= center_y;
      rad_q   <= radius;
      shw_q   <= shell_w;
      mode_q  <= mode_e'(mode);
      color_q <= color;
      row_q   <= '0;
      columns <= '0;
    end else if (scanning) begin
      for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
        columns[0][row_idx[k]] <= pix[0][k];
        columns[1][row_idx[k]] <= pix[1][k];
      end
      // Wraps to zero after the final group; harmless, IDLE reloads it.
      row_q <= row_q + CY_W'(ROWS_PER_CYCLE);
    end
  end

endmodule

// File: tb/tb_shape_column_gen.sv
// Directed self-checking bench for shape_column_gen: one instance with one
// row per cycle and one with four rows per cycle, hand-computed expectations.
module tb_shape_column_gen;

  localparam int NC = 64;
  localparam int NR = 64;
  localparam int RB = 9;
  localparam int CW = NR * RB;

  logic clk = 1'b0;
  logic rst_in;

  logic          req_valid, req_ready, out_valid, out_ready;
  logic          req_valid4, req_ready4, out_valid4, out_ready4;
  logic [5:0]    c1, c2, cx, cy, rad, sw;
  logic [1:0]    md;
  logic [RB-1:0] colr;
  logic [1:0][NR-1:0][RB-1:0] columns, columns4;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shape_column_gen #(.NUM_COLS(NC), .NUM_ROWS(NR), .RGB_RES(RB), .ROWS_PER_CYCLE(1)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .column_index1 (c1),
    .column_index2 (c2),
    .center_x      (cx),
    .center_y      (cy),
    .radius        (rad),
    .shell_w       (sw),
    .mode          (md),
    .color         (colr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .columns       (columns)
  );

  shape_column_gen #(.NUM_COLS(NC), .NUM_ROWS(NR), .RGB_RES(RB), .ROWS_PER_CYCLE(4)) dut4 (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .req_valid     (req_valid4),
    .req_ready     (req_ready4),
    .column_index1 (c1),
    .column_index2 (c2),
    .center_x      (cx),
    .center_y      (cy),
    .radius        (rad),
    .shell_w       (sw),
    .mode          (md),
    .color         (colr),
    .out_valid     (out_valid4),
    .out_ready     (out_ready4),
    .columns       (columns4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits a..b set: the hand-chosen lit rows of a column.
  function automatic logic [NR-1:0] rng(input int a, input int b);
    logic [NR-1:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] mk_col(input logic [NR-1:0] mask, input logic [RB-1:0] c);
    logic [CW-1:0] v = '0;
    for (int y = 0; y < NR; y++) if (mask[y]) v[y*RB +: RB] = c;
    return v;
  endfunction

  task automatic set_req(input logic [5:0] a1, a2, ax, ay, ar, asw,
                         input logic [1:0] am, input logic [RB-1:0] ac);
    c1 = a1; c2 = a2; cx = ax; cy = ay; rad = ar; sw = asw; md = am; colr = ac;
  endtask

  // Accept a request, then wait (bounded) for out_valid, checking latency and
  // that req_ready stays low from SCAN into DONE.
  task automatic run_frame(input string tag);
    int   cycles = 0;
    logic rdy_seen = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    while (!out_valid && cycles < 200) begin
      rdy_seen |= req_ready;
      tick();
      cycles++;
    end
    rdy_seen |= req_ready;
    check({tag, "_latency"}, CW'(cycles), CW'(64));
    check({tag, "_ready_low"}, CW'(rdy_seen), CW'(0));
  endtask

  task automatic check_cols(input string tag, input logic [NR-1:0] m0, m1, input logic [RB-1:0] c);
    check({tag, "_col0"}, columns[0], mk_col(m0, c));
    check({tag, "_col1"}, columns[1], mk_col(m1, c));
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_fall"}, CW'(out_valid), CW'(0));
    check({tag, "_ready_back"}, CW'(req_ready), CW'(1));
  endtask

  initial begin
    logic stable;
    int   cycles;

    rst_in = 1'b1;
    req_valid = 1'b0; out_ready = 1'b0;
    req_valid4 = 1'b0; out_ready4 = 1'b0;
    set_req(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd0, '0);
    tick();
    check("reset_out_valid", CW'(out_valid), CW'(0));
    check("reset_req_ready", CW'(req_ready), CW'(1));
    check("reset_col0", columns[0], '0);
    check("reset_col1", columns[1], '0);
    rst_in = 1'b0;
    tick();

    // FILLED, centre (32,32), r=4: col 32 rows 28..36, col 36 only row 32.
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd0, 2'd1, 9'h1FF);
    run_frame("filled");
    check_cols("filled", rng(28, 36), rng(32, 32), 9'h1FF);
    release_frame("filled");

    // SHELL w=1: ri2=9, so only |dy| in {3,4} on col 32; col 36 keeps row 32.
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd1, 2'd2, 9'h1FF);
    run_frame("shell");
    check_cols("shell", rng(28, 29) | rng(35, 36), rng(32, 32), 9'h1FF);
    release_frame("shell");

    // SHELL thicker than the radius behaves as FILLED.
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd9, 2'd2, 9'h055);
    run_frame("shell_wide");
    check_cols("shell_wide", rng(28, 36), rng(32, 32), 9'h055);
    release_frame("shell_wide");

    set_req(6'd3, 6'd60, 6'd32, 6'd32, 6'd4, 6'd0, 2'd3, 9'h1AB);
    run_frame("solid");
    check_cols("solid", '1, '1, 9'h1AB);
    release_frame("solid");

    set_req(6'd32, 6'd32, 6'd32, 6'd32, 6'd4, 6'd0, 2'd0, 9'h1AB);
    run_frame("off");
    check_cols("off", '0, '0, 9'h1AB);
    release_frame("off");

    // Both columns the same x (dx=2): dy^2 <= 12 -> rows 29..35 in both.
    set_req(6'd34, 6'd34, 6'd32, 6'd32, 6'd4, 6'd0, 2'd1, 9'h0F0);
    run_frame("same_col");
    check_cols("same_col", rng(29, 35), rng(29, 35), 9'h0F0);
    release_frame("same_col");

    // Backpressure: hold DONE for 10 cycles while the request side churns.
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd0, 2'd1, 9'h1FF);
    run_frame("bp");
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(6'(i), 6'(i + 7), 6'(i), 6'(60 - i), 6'(i + 1), 6'd0, 2'(i), 9'(i * 37));
      req_valid = i[0];
      tick();
      stable &= out_valid && !req_ready &&
                (columns[0] === mk_col(rng(28, 36), 9'h1FF)) &&
                (columns[1] === mk_col(rng(32, 32), 9'h1FF));
    end
    req_valid = 1'b0;
    check("bp_stable", CW'(stable), CW'(1));
    check_cols("bp", rng(28, 36), rng(32, 32), 9'h1FF);
    release_frame("bp");

    // Reset while row 20 is being evaluated aborts the frame at once.
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd0, 2'd3, 9'h1C7);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (20) tick();
    rst_in = 1'b1;
    #2;
    check("abort_out_valid", CW'(out_valid), CW'(0));
    check("abort_req_ready", CW'(req_ready), CW'(1));
    check("abort_col0", columns[0], '0);
    check("abort_col1", columns[1], '0);
    #1;
    rst_in = 1'b0;
    set_req(6'd32, 6'd36, 6'd32, 6'd32, 6'd4, 6'd1, 2'd2, 9'h1FF);
    run_frame("post_abort");
    check_cols("post_abort", rng(28, 29) | rng(35, 36), rng(32, 32), 9'h1FF);
    release_frame("post_abort");

    // Four rows per cycle: r=0 centre (10,5) lights only col 10 row 5.
    set_req(6'd10, 6'd11, 6'd10, 6'd5, 6'd0, 6'd0, 2'd1, 9'h1FF);
    req_valid4 = 1'b1;
    tick();
    req_valid4 = 1'b0;
    cycles = 0;
    while (!out_valid4 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("rpc4_latency", CW'(cycles), CW'(16));
    check("rpc4_col0", columns4[0], mk_col(rng(5, 5), 9'h1FF));
    check("rpc4_col1", columns4[1], '0);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("rpc4_valid_fall", CW'(out_valid4), CW'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
